// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer.
//
// countdown_state_e : controller state
//   CD_IDLE - waiting for a load; load_ready is high
//   CD_RUN  - counting enabled ticks down toward zero
//   CD_DONE - interval elapsed; done_valid held until acknowledged
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    CD_IDLE = 2'd0,
    CD_RUN  = 2'd1,
    CD_DONE = 2'd2
  } countdown_state_e;

endpackage : countdown_timer_pkg

// File: rtl/countdown_timer.sv
// countdown_timer
//
// Loadable down-counter. A length is accepted over the load handshake, the
// timer decrements once per enabled cycle, and expiry is reported over the
// done handshake. Once done is acknowledged the timer returns to idle and can
// accept the next load on the following edge.
//
// Parameters
//   WIDTH      - width of load_value and count
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (priority over all inputs)
//   en         in   tick enable, only effective while running
//   load_valid in   load request
//   load_ready out  timer idle and able to take a load
//   load_value in   interval length in enabled ticks (unsigned)
//   count      out  remaining ticks (registered)
//   busy       out  running or waiting for done acknowledge
//   done_valid out  interval expired, awaiting acknowledge
//   done_ready in   done acknowledge
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Decrement as an add of all-ones (-1 mod 2^WIDTH). RUN never holds zero,
  // so the wrap case is unreachable.
  function automatic logic [WIDTH-1:0] dec_count(input logic [WIDTH-1:0] v);
    return v + ALL_ONES;
  endfunction

  countdown_state_e state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      CD_IDLE: begin
        if (load_valid) begin
          if (load_value == '0) begin
            // A zero-length interval expires immediately.
            state_d = CD_DONE;
            count_d = '0;
          end else begin
            state_d = CD_RUN;
            count_d = load_value;
          end
        end
      end
      CD_RUN: begin
        if (en) begin
          count_d = dec_count(count_q);
          // The tick that takes count from 1 to 0 also ends the interval.
          if (count_q == ONE) begin
            state_d = CD_DONE;
          end
        end
      end
      CD_DONE: begin
        count_d = '0;
        if (done_ready) begin
          state_d = CD_IDLE;
        end
      end
      default: begin
        state_d = CD_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Handshake outputs decode the state register only; no input feeds them.
  assign load_ready = (state_q == CD_IDLE);
  assign done_valid = (state_q == CD_DONE);
  assign busy       = (state_q != CD_IDLE);
  assign count      = count_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done_valid;
  logic             done_ready;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .count      (count),
    .busy       (busy),
    .done_valid (done_valid),
    .done_ready (done_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int count;
    bit load_ready;
    bit busy;
    bit done_valid;
  } snap_t;

  snap_t exp_q[$];   // expected outputs after each driven edge
  int    done_q[$];  // edge number at which each done_valid should first appear

  int checks = 0;
  int errors = 0;

  // Reference model: an interval is either absent (-1), a number of enabled
  // ticks still owed, or finished and waiting for acknowledge.
  int ticks_left = -1;
  bit waiting_ack = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, req);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge and
  // queue what the DUT should show after that edge.
  task automatic cycle(input bit r, input bit e, input bit lv, input int val, input bit dr);
    snap_t s;
    int    next_edge;
    @(negedge clk);
    rst        = r;
    en         = e;
    load_valid = lv;
    load_value = WIDTH'(val);
    done_ready = dr;
    next_edge  = edge_n + 1;
    if (r) begin
      ticks_left  = -1;
      waiting_ack = 1'b0;
    end else if (waiting_ack) begin
      if (dr) waiting_ack = 1'b0;
    end else if (ticks_left > 0) begin
      if (e) begin
        ticks_left--;
        if (ticks_left == 0) begin
          ticks_left  = -1;
          waiting_ack = 1'b1;
          done_q.push_back(next_edge);
        end
      end
    end else if (lv) begin
      if (val == 0) begin
        waiting_ack = 1'b1;
        done_q.push_back(next_edge);
      end else begin
        ticks_left = val;
      end
    end
    s.done_valid = waiting_ack;
    s.load_ready = !waiting_ack && (ticks_left < 0);
    s.busy       = !s.load_ready;
    s.count      = (ticks_left > 0) ? ticks_left : 0;
    exp_q.push_back(s);
  endtask

  // Monitor: compares registered outputs after every edge and matches each
  // new done_valid against the scoreboard of expected expiries.
  bit prev_done = 1'b0;
  initial begin
    snap_t s;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check("count",      int'(count),      s.count);
        check("load_ready", int'(load_ready), int'(s.load_ready));
        check("busy",       int'(busy),       int'(s.busy));
        check("done_valid", int'(done_valid), int'(s.done_valid));
      end
      if (done_valid === 1'b1 && !prev_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("done_edge", edge_n, done_q.pop_front());
        end
      end
      prev_done = (done_valid === 1'b1);
    end
  end

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    load_valid = 1'b0;
    load_value = '0;
    done_ready = 1'b0;

    // Reset held with a pending load request: nothing may be accepted.
    cycle(1, 1, 1, 7, 0);
    cycle(1, 1, 1, 7, 0);

    // Basic countdown of 5 with en high, then one-cycle acknowledge.
    cycle(0, 1, 1, 5, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // Gated ticks: load 3, then en pattern 1,0,0,1,1.
    cycle(0, 0, 1, 3, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);

    // Zero-length load expires one cycle after the handshake.
    cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 1);

    // Maximum load value; count must never wrap back to 255.
    cycle(0, 1, 1, 255, 0);
    for (int i = 0; i < 255; i++) cycle(0, 1, 0, 0, 0);

    // Backpressure in DONE with a load request pending, then release.
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 9, 0);
    cycle(0, 1, 1, 9, 1);
    cycle(0, 1, 1, 2, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);

    // Mid-run reset after 4 ticks of a 10-tick interval: no done for it.
    cycle(0, 1, 1, 10, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0, 0);

    // Reset while in DONE also discards the pending done.
    cycle(0, 1, 1, 1, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      int v;
      bit r;
      v = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 6));
      r = ($urandom_range(0, 199) == 0);
      cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, v,
            $urandom_range(0, 1) == 1);
    end

    // Drain: acknowledge anything outstanding and let the monitor catch up.
    for (int i = 0; i < 300 && (ticks_left > 0 || waiting_ack); i++) cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("done_queue_empty", done_q.size(), 0);
    check("exp_queue_empty",  exp_q.size(),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter that consumes a count value over a ready/valid load handshake. It decrements once per enabled cycle and reports expiry over a ready/valid done handshake. It complements the free-running up-counter: a requester supplies a length, the timer counts it back to zero, and the requester is told when the interval has elapsed. Typical use: interval timers, backoff delays, and burst-length trackers alongside pyc_fifo/pyc_queue consumers.

## Interface
Parameters:
- WIDTH, default 8: width of the load value and the count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  tick enable; decrement happens only in RUN with en high.
- load_valid  input  1  load request valid.
- load_ready  output  1  timer can accept a load.
- load_value  input  WIDTH  interval length in enabled ticks; unsigned.
- count  output  WIDTH  remaining ticks (registered).
- busy  output  1  high in RUN or DONE.
- done_valid  output  1  interval expired, awaiting acknowledge.
- done_ready  input  1  acknowledge of done.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - load_ready=1.
  - On load_valid && load_ready:
    - load_value==0 → DONE, count<=0.
    - Otherwise → RUN, count<=load_value.
  - Without load_valid, the timer holds.
- RUN:
  - load_ready=0.
  - en=1 → count<=count-1. If count==1, the same edge also moves to DONE (count becomes 0).
  - en=0 → hold count and state.
- DONE:
  - done_valid=1, load_ready=0, count=0.
  - done_ready=1 → IDLE on that edge.
  - done_valid holds until acknowledged, independent of en.
- busy = (state != IDLE).
- Arithmetic:
  - Decrement is modulo 2^WIDTH but can never underflow, because RUN never holds count 0.
  - The maximum load value 2^WIDTH-1 is legal.
- load_value is sampled only at the handshake edge. Changes at other times have no effect.
- en in IDLE or DONE has no effect.
- load_ready and done_valid are pure functions of the state register, with no combinational path from any input.

## Timing
- Reset values: state=IDLE, count=0, busy=0, done_valid=0, load_ready=1.
- Reset mid-operation (in RUN or DONE):
  - Returns to IDLE on the next edge and discards the pending interval.
  - No done is produced for that interval.
- Latency with load value N≥1 and en held high:
  - Load handshake at edge E0.
  - count=N after E0, decrementing by 1 per edge.
  - count=0 and done_valid=1 after edge E0+N.
- Load value 0: done_valid=1 after E0, i.e. one cycle after the handshake.
- With en gaps: done follows the N-th enabled edge after E0.
- Done acknowledge:
  - done_valid && done_ready at edge Ed → IDLE, load_ready=1 after Ed.
  - A new load can be accepted no earlier than edge Ed+1.
  - Minimum back-to-back turnaround is therefore one idle cycle.
- rst takes priority over every other input on the same edge.

## Structure
- Shared package (alongside pyc_handshake_pkg): typedef enum logic [1:0] countdown_state_e {CD_IDLE, CD_RUN, CD_DONE}.
- Count and state registers are pyc_reg instances with init=0 / CD_IDLE.
- The next-count select uses pyc_mux.
- The decrement is a pyc_add of the count with all-ones, i.e. -1 mod 2^WIDTH.
- No new sub-module is needed.

## Test plan
- Reset: hold rst for 2 cycles with load_valid=1 → count=0, load_ready=1, busy=0, done_valid=0 throughout; no load accepted.
- Basic: en=1, load 5 → count 5,4,3,2,1,0 on successive edges; done_valid=1 after edge E0+5; done_ready=1 for one cycle → IDLE, load_ready=1.
- Gated ticks: load 3, en toggling 1,0,0,1,1 → count 3→2 (hold, hold)→1→0; done_valid appears only after the third enabled edge.
- Zero and max: load 0 → done_valid one cycle after the handshake. WIDTH=8, load 255 → done after 255 enabled edges, count never wraps to 255 again.
- Backpressure and reload: in DONE, hold done_ready=0 for 4 cycles with load_valid=1 → done_valid stays 1, load_ready=0, no load accepted. Release done_ready → load accepted on the following cycle.
- Mid-run reset: load 10, assert rst after 4 ticks (count=6) → IDLE, count=0 next edge; no done_valid pulse ever appears for that interval.
